// File: rtl/seg_scan_if.sv
// seg_scan_if: update handshake between a pattern source and seg_scan.
//   upd_valid  source -> sink  a new pattern set is offered
//   upd_ready  sink -> source  the sink can accept a pattern set
//   upd_segs   source -> sink  DIGITS x 8-bit patterns, digit i in [8i+7:8i]
// A transfer happens on a clock edge where upd_valid and upd_ready are both high.
interface seg_scan_if #(
  parameter int DIGITS = 8
);
  logic                  upd_valid;
  logic                  upd_ready;
  logic [8*DIGITS-1:0]   upd_segs;

  modport master (output upd_valid, output upd_segs, input upd_ready);
  modport slave  (input upd_valid, input upd_segs, output upd_ready);
endinterface

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment driver with double-buffered
// pattern updates, inter-digit blanking and per-digit enables.
//   clk, rst     clock and synchronous active-high reset
//   upd          seg_scan_if slave: pattern set handshake
//   digit_en     per-digit enable, sampled live every cycle
//   seg_out      shared segment bus (pin polarity), registered
//   an_out       one anode per digit (pin polarity), registered
//   frame_done   one-cycle pulse in the cycle after the last cycle of a frame
module seg_scan #(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_if.slave         upd,
  input  logic [DIGITS-1:0] digit_en,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] an_out,
  output logic              frame_done
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [8*DIGITS-1:0] pend_buf_q, pend_buf_d;
  logic                pend_vld_q, pend_vld_d;
  logic [8*DIGITS-1:0] act_buf_q, act_buf_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                blank;
  logic                lit;
  logic                boundary;
  logic [7:0]          digit_pat [DIGITS];
  logic [DIGITS-1:0]   an_logic;

  // Blanking at the head of each slot; with no blanking the compare is
  // dropped entirely rather than comparing against zero.
  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (pre_q < PRE_W'(BLANK_CYC));
    end
  endgenerate

  assign lit = !blank && digit_en[idx_q];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_pat[gi] = act_buf_q[8*gi +: 8];
      assign an_logic[gi]  = lit && (idx_q == IDX_W'(gi));
    end
  endgenerate

  assign boundary = (idx_q == IDX_LAST) && (pre_q == PRE_LAST);

  always_comb begin
    pre_d        = pre_q + 1'b1;
    idx_d        = idx_q;
    pend_buf_d   = pend_buf_q;
    pend_vld_d   = pend_vld_q;
    act_buf_d    = act_buf_q;
    frame_done_d = boundary;

    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Transfer and capture are mutually exclusive: a capture needs an empty
    // pending buffer, a transfer needs a full one. A capture on the boundary
    // cycle therefore waits for the following boundary.
    if (boundary && pend_vld_q) begin
      act_buf_d  = pend_buf_q;
      pend_vld_d = 1'b0;
    end else if (upd.upd_valid && !pend_vld_q) begin
      pend_buf_d = upd.upd_segs;
      pend_vld_d = 1'b1;
    end

    // Segments are gated by the same condition as the anodes, so nothing is
    // driven while every anode is off.
    seg_d = (lit ? digit_pat[idx_q] : 8'h00) ^ {8{POL}};
    an_d  = an_logic ^ {DIGITS{POL}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pend_buf_q   <= '0;
      pend_vld_q   <= 1'b0;
      act_buf_q    <= '0;
      seg_q        <= {8{POL}};
      an_q         <= {DIGITS{POL}};
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pend_buf_q   <= pend_buf_d;
      pend_vld_q   <= pend_vld_d;
      act_buf_q    <= act_buf_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign upd.upd_ready = !pend_vld_q;
  assign seg_out       = seg_q;
  assign an_out        = an_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan (DIGITS=8, SCAN_DIV=4,
// BLANK_CYC=1, ACTIVE_LOW=1). A cycle model feeds a scoreboard queue on
// every step; table vectors and hand sequences add fixed expectations.
module tb_seg_scan;
  localparam int DIGITS    = 8;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIGITS-1:0] digit_en;
  logic [7:0]        seg_out;
  logic [DIGITS-1:0] an_out;
  logic              frame_done;

  seg_scan_if #(.DIGITS(DIGITS)) u_if ();

  seg_scan #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .upd(u_if), .digit_en(digit_en),
    .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] an;
    logic       fd;
    logic       rdy;
  } exp_t;

  typedef struct {
    logic [7:0] en;
    int         slot;
    int         off;
    logic [7:0] an;
    logic [7:0] seg;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state, following the behavioural description directly.
  int         m_pre, m_idx;
  logic [7:0] m_act  [DIGITS];
  logic [7:0] m_pend [DIGITS];
  logic       m_pvld;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict the post-edge outputs from the current inputs,
  // queue them, cross the edge, then pop and compare.
  task automatic step();
    exp_t       e;
    logic       lit, bnd;
    logic [7:0] seg_l, an_l;
    if (rst) begin
      e = '{8'hFF, 8'hFF, 1'b0, 1'b1};
      m_pre = 0; m_idx = 0; m_pvld = 1'b0;
      for (int i = 0; i < DIGITS; i++) m_act[i] = 8'h00;
    end else begin
      lit   = (m_pre >= BLANK_CYC) && digit_en[m_idx];
      an_l  = lit ? (8'h01 << m_idx) : 8'h00;
      seg_l = lit ? m_act[m_idx] : 8'h00;
      bnd   = (m_idx == DIGITS - 1) && (m_pre == SCAN_DIV - 1);
      if (bnd && m_pvld) begin
        for (int i = 0; i < DIGITS; i++) m_act[i] = m_pend[i];
        m_pvld = 1'b0;
      end else if (u_if.upd_valid && !m_pvld) begin
        for (int i = 0; i < DIGITS; i++) m_pend[i] = u_if.upd_segs[8*i +: 8];
        m_pvld = 1'b1;
        $display("update handshake at %0t: segs=%h", $time, u_if.upd_segs);
      end
      if (m_pre == SCAN_DIV - 1) begin
        m_pre = 0;
        m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
      end else begin
        m_pre++;
      end
      e = '{~seg_l, ~an_l, bnd, !m_pvld};
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_seg", seg_out, e.seg);
    chk("sb_an", an_out, e.an);
    chk("sb_fd", {7'd0, frame_done}, {7'd0, e.fd});
    chk("sb_rdy", {7'd0, u_if.upd_ready}, {7'd0, e.rdy});
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_fd: frame_done not seen after %0d cycles", n);
    end
  endtask

  vec_t vecs[10];
  int   n;

  initial begin
    vecs[0] = '{8'hFF, 0, 0, 8'hFF, 8'hFF};
    vecs[1] = '{8'hFF, 0, 1, 8'hFE, 8'h02};
    vecs[2] = '{8'hFF, 0, 3, 8'hFE, 8'h02};
    vecs[3] = '{8'hFF, 1, 0, 8'hFF, 8'hFF};
    vecs[4] = '{8'hFF, 1, 2, 8'hFD, 8'h9F};
    vecs[5] = '{8'hFF, 2, 1, 8'hFB, 8'hFF};
    vecs[6] = '{8'h0F, 4, 1, 8'hFF, 8'hFF};
    vecs[7] = '{8'h0F, 7, 3, 8'hFF, 8'hFF};
    vecs[8] = '{8'h0F, 3, 2, 8'hF7, 8'hFF};
    vecs[9] = '{8'h0F, 1, 1, 8'hFD, 8'h9F};

    rst = 1'b1;
    u_if.upd_valid = 1'b0;
    u_if.upd_segs  = '0;
    digit_en = 8'hFF;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_seg", seg_out, 8'hFF);
    chk("rst_an", an_out, 8'hFF);
    chk("rst_rdy", {7'd0, u_if.upd_ready}, 8'd1);
    chk("rst_fd", {7'd0, frame_done}, 8'd0);

    // First update one cycle after release, then a refused second offer.
    step();
    u_if.upd_valid = 1'b1;
    u_if.upd_segs  = {48'h0, 8'h60, 8'hFD};
    step();
    chk("ready_falls", {7'd0, u_if.upd_ready}, 8'd0);
    u_if.upd_segs  = {48'h0, 8'h00, 8'hFF};
    repeat (3) step();
    u_if.upd_valid = 1'b0;
    chk("ready_held", {7'd0, u_if.upd_ready}, 8'd0);
    wait_fd(n);
    chk_int("first_fd_cycle", n + 5, 32);
    chk("ready_back", {7'd0, u_if.upd_ready}, 8'd1);

    foreach (vecs[v]) begin
      digit_en = vecs[v].en;
      wait_fd(n);
      repeat (4 * vecs[v].slot + vecs[v].off + 1) step();
      chk($sformatf("vec%0d_an", v), an_out, vecs[v].an);
      chk($sformatf("vec%0d_seg", v), seg_out, vecs[v].seg);
    end

    digit_en = 8'h0F;
    wait_fd(n);
    wait_fd(n);
    chk_int("period_en0f", n, 32);

    // Offer exactly on the boundary cycle: old set stays one more frame.
    digit_en = 8'hFF;
    repeat (31) step();
    u_if.upd_valid = 1'b1;
    u_if.upd_segs  = {56'h0, 8'h3F};
    step();
    u_if.upd_valid = 1'b0;
    chk("bnd_fd", {7'd0, frame_done}, 8'd1);
    chk("bnd_captured", {7'd0, u_if.upd_ready}, 8'd0);
    repeat (2) step();
    chk("old_kept_an", an_out, 8'hFE);
    chk("old_kept_seg", seg_out, 8'h02);
    wait_fd(n);
    chk("bnd_ready_back", {7'd0, u_if.upd_ready}, 8'd1);
    repeat (2) step();
    chk("new_shown_seg", seg_out, 8'hC0);

    // Reset in the digit-3 slot with an update pending.
    u_if.upd_valid = 1'b1;
    u_if.upd_segs  = {56'h0, 8'h06};
    step();
    u_if.upd_valid = 1'b0;
    chk("pend_full", {7'd0, u_if.upd_ready}, 8'd0);
    repeat (12) step();
    chk("slot3_an", an_out, 8'hF7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_an", an_out, 8'hFF);
    chk("mid_rst_seg", seg_out, 8'hFF);
    chk("mid_rst_rdy", {7'd0, u_if.upd_ready}, 8'd1);
    repeat (2) step();
    chk("restart_an", an_out, 8'hFE);
    chk("restart_seg", seg_out, 8'hFF);
    wait_fd(n);
    chk_int("restart_fd_cycle", n + 2, 32);
    repeat (2) step();
    chk("pend_dropped_seg", seg_out, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
